node_ejector: RTL

Ejection-side network interface for one mesh node. It sits on the router's LOCAL output port and receives `flit_t` flits tagged with a VC. It buffers them per VC and returns credits upstream. Toward the node it emits whole packets one at a time, without interleaving. Head flits are checked against the node's own coordinates.

---
 rtl/noc_params.sv | 40 ++++
 rtl/ejector_vc_fifo.sv | 54 +++++
 rtl/node_ejector.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/noc_params.sv
// Shared NoC parameters and flit types; the ejector-specific additions are at the bottom.
package noc_params;

  localparam int VC_NUM           = 2;
  localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int FLIT_DATA_SIZE   = 16;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } flit_label_t;

  typedef struct packed {
    logic [VC_SIZE-1:0]          vc_id;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
  } head_data_t;

  typedef struct packed {
    flit_label_t               flit_label;
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;

  localparam int EJECT_BUFFER_SIZE = 8;

  typedef enum logic {
    EJ_IDLE,
    EJ_LOCKED
  } ejector_state_t;

  // Round-robin successor that also works when VC_NUM is not a power of two.
  function automatic logic [VC_SIZE-1:0] next_vc(input logic [VC_SIZE-1:0] v);
    return (int'(v) == VC_NUM - 1) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/ejector_vc_fifo.sv
// Per-VC flit FIFO: circular buffer with occupancy counter and a combinational front view.
module ejector_vc_fifo
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = EJECT_BUFFER_SIZE
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  flit_t data_in,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output flit_t front
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  flit_t            mem [BUFFER_SIZE];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(BUFFER_SIZE));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign front   = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset: emptiness is tracked by the counter alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= data_in;
  end

endmodule

// File: rtl/node_ejector.sv
// Ejection NI: per-VC buffering with credits, packet-atomic round-robin delivery to the node.
module node_ejector
  import noc_params::*;
#(
  parameter logic [DEST_ADDR_SIZE_X-1:0] X_CURRENT   = '0,
  parameter logic [DEST_ADDR_SIZE_Y-1:0] Y_CURRENT   = '0,
  parameter int                          BUFFER_SIZE = EJECT_BUFFER_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              flit_i,
  input  logic               valid_flit_i,
  input  logic [VC_SIZE-1:0] vc_i,
  output logic [VC_NUM-1:0]  credit_o,
  output logic [VC_NUM-1:0]  is_allocatable_o,
  output flit_t              node_flit_o,
  output logic               node_valid_o,
  input  logic               node_ready_i,
  output logic [VC_SIZE-1:0] node_vc_o,
  output logic               misroute_o,
  output logic               proto_err_o
);

  logic [VC_NUM-1:0] rx_open_reg, rx_open_next;
  logic [VC_NUM-1:0] vc_hit, label_ok, push, pop;
  logic [VC_NUM-1:0] full, empty, eligible;
  flit_t             front [VC_NUM];

  logic [VC_NUM-1:0] credit_reg;
  logic              misroute_reg, misroute_next;
  logic              proto_err_reg, proto_err_next;
  logic              accepted, head_accepted;

  ejector_state_t     state_reg, state_next;
  logic [VC_SIZE-1:0] lock_vc_reg, lock_vc_next;
  logic [VC_SIZE-1:0] rr_ptr_reg, rr_ptr_next;
  logic               hold_reg, hold_next;
  logic [VC_SIZE-1:0] hold_vc_reg, hold_vc_next;

  logic               arb_found;
  logic [VC_SIZE-1:0] arb_vc;
  logic [VC_SIZE-1:0] sel_vc;
  logic               handshake;

  generate
    for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
      assign vc_hit[gi]   = valid_flit_i && (vc_i == VC_SIZE'(gi));
      assign label_ok[gi] = (flit_i.flit_label == HEAD) ? ~rx_open_reg[gi] :
                            ((flit_i.flit_label == BODY) || (flit_i.flit_label == TAIL)) ?
                            rx_open_reg[gi] : 1'b0;
      assign push[gi]     = vc_hit[gi] & label_ok[gi] & ~full[gi];
      // A HEAD opens the VC, BODY keeps it open, TAIL closes it.
      assign rx_open_next[gi] = push[gi] ? (flit_i.flit_label != TAIL) : rx_open_reg[gi];

      assign eligible[gi]         = ~empty[gi] & (front[gi].flit_label == HEAD);
      assign is_allocatable_o[gi] = ~rx_open_reg[gi] & empty[gi];
      assign pop[gi]              = handshake & (sel_vc == VC_SIZE'(gi));

      ejector_vc_fifo #(
        .BUFFER_SIZE(BUFFER_SIZE)
      ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push[gi]),
        .data_in(flit_i),
        .pop    (pop[gi]),
        .full   (full[gi]),
        .empty  (empty[gi]),
        .front  (front[gi])
      );
    end
  endgenerate

  assign accepted      = |push;
  assign head_accepted = accepted & (flit_i.flit_label == HEAD);

  always_comb begin
    proto_err_next = (valid_flit_i & ~accepted) |
                     (head_accepted & (flit_i.head_data.vc_id != vc_i));
    misroute_next  = head_accepted &
                     ((flit_i.head_data.x_dest != X_CURRENT) ||
                      (flit_i.head_data.y_dest != Y_CURRENT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_open_reg   <= '0;
      credit_reg    <= '0;
      misroute_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      rx_open_reg   <= rx_open_next;
      credit_reg    <= pop;
      misroute_reg  <= misroute_next;
      proto_err_reg <= proto_err_next;
    end
  end

  assign credit_o    = credit_reg;
  assign misroute_o  = misroute_reg;
  assign proto_err_o = proto_err_reg;

  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_vc    = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      idx = (int'(rr_ptr_reg) + i) % VC_NUM;
      if (!arb_found && eligible[idx]) begin
        arb_found = 1'b1;
        arb_vc    = VC_SIZE'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= EJ_IDLE;
      lock_vc_reg <= '0;
      rr_ptr_reg  <= '0;
      hold_reg    <= 1'b0;
      hold_vc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lock_vc_reg <= lock_vc_next;
      rr_ptr_reg  <= rr_ptr_next;
      hold_reg    <= hold_next;
      hold_vc_reg <= hold_vc_next;
    end
  end

  assign handshake = node_valid_o & node_ready_i;

  // A stalled head offer is pinned so a newly arriving higher-priority head
  // cannot swap the presented flit before the node accepts it.
  always_comb begin
    state_next   = state_reg;
    lock_vc_next = lock_vc_reg;
    rr_ptr_next  = rr_ptr_reg;
    hold_next    = 1'b0;
    hold_vc_next = hold_vc_reg;
    case (state_reg)
      EJ_IDLE: begin
        if (handshake) begin
          state_next   = EJ_LOCKED;
          lock_vc_next = sel_vc;
        end else if (node_valid_o) begin
          hold_next    = 1'b1;
          hold_vc_next = sel_vc;
        end
      end
      EJ_LOCKED: begin
        if (handshake && (front[lock_vc_reg].flit_label == TAIL)) begin
          state_next  = EJ_IDLE;
          rr_ptr_next = next_vc(lock_vc_reg);
        end
      end
      default: state_next = EJ_IDLE;
    endcase
  end

  always_comb begin
    sel_vc       = '0;
    node_valid_o = 1'b0;
    case (state_reg)
      EJ_IDLE: begin
        if (hold_reg) begin
          sel_vc       = hold_vc_reg;
          node_valid_o = 1'b1;
        end else begin
          sel_vc       = arb_vc;
          node_valid_o = arb_found;
        end
      end
      EJ_LOCKED: begin
        sel_vc       = lock_vc_reg;
        node_valid_o = ~empty[lock_vc_reg];
      end
      default: begin
        sel_vc       = '0;
        node_valid_o = 1'b0;
      end
    endcase
    node_vc_o   = node_valid_o ? sel_vc : '0;
    node_flit_o = node_valid_o ? front[sel_vc] : '0;
  end

endmodule
